// File: rtl/clk_meter.sv
// Gated edge-count frequency meter for an asynchronous input, clocked on the system clock.
// Optional first-to-last edge period measurement is enabled by defining CLK_METER_PERIOD_EN.
module clk_meter #(
   parameter int unsigned GATE_CYCLES = 100000000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             start,
   input  logic             continuous,
   output logic             busy,
   output logic             valid,
   output logic [CNT_W-1:0] freq_cnt,
   output logic             overflow,
   output logic [31:0]      period_cnt
);

   localparam int unsigned   GW        = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GATE = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic             s1, s2, s3;
   logic             sig_rise;
   logic             last_cycle;
   logic             arm;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf;
   logic             ovf_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Saturating next count; the last gate cycle latches these so its own edge is included.
   always_comb begin
      sig_rise   = s2 & ~s3;
      last_cycle = (gate_cnt == GATE_LAST);
      arm        = ((state == IDLE) && start) || ((state == DONE) && continuous);
      cnt_nxt    = edge_cnt;
      ovf_nxt    = ovf;
      if (sig_rise) begin
         if (&edge_cnt) ovf_nxt = 1'b1;
         else           cnt_nxt = edge_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf      <= 1'b0;
         freq_cnt <= '0;
         overflow <= 1'b0;
      end else if (arm) begin
         state    <= GATE;
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            GATE: begin
               gate_cnt <= gate_cnt + 1'b1;
               edge_cnt <= cnt_nxt;
               ovf      <= ovf_nxt;
               if (last_cycle) begin
                  freq_cnt <= cnt_nxt;
                  overflow <= ovf_nxt;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy  = (state != IDLE);
   assign valid = (state == DONE);

`ifdef CLK_METER_PERIOD_EN
   logic        per_run;
   logic        multi;
   logic [31:0] per_time;
   logic [31:0] last_edge;
   logic [31:0] time_now;
   logic [31:0] last_nxt;
   logic        multi_nxt;

   // Time base reads 0 on the first edge of the window, then counts every cycle.
   always_comb begin
      time_now  = per_run ? per_time : '0;
      last_nxt  = sig_rise ? time_now : last_edge;
      multi_nxt = multi | (sig_rise & per_run);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_run    <= 1'b0;
         multi      <= 1'b0;
         per_time   <= '0;
         last_edge  <= '0;
         period_cnt <= '0;
      end else if (arm) begin
         per_run   <= 1'b0;
         multi     <= 1'b0;
         per_time  <= '0;
         last_edge <= '0;
      end else if (state == GATE) begin
         if (sig_rise) per_run <= 1'b1;
         if (per_run || sig_rise) per_time <= (&time_now) ? time_now : time_now + 32'd1;
         last_edge <= last_nxt;
         multi     <= multi_nxt;
         if (last_cycle) period_cnt <= multi_nxt ? last_nxt : '0;
      end
   end
`else
   assign period_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_meter.sv
// Self-checking bench for clk_meter: table vectors, hand sequences and a randomized run
// against a window-level reference model built from a history of sampled sig_in values.
module tb_clk_meter;

   localparam int G      = 100;
   localparam int SAMP_N = 16384;
`ifdef CLK_METER_PERIOD_EN
   localparam bit PER_EN = 1'b1;
`else
   localparam bit PER_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sig_in = 1'b0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic        busy, valid, overflow;
   logic [31:0] freq_cnt, period_cnt;
   logic        busy4, valid4, overflow4;
   logic [3:0]  freq_cnt4;
   logic [31:0] period_cnt4;

   int n_cmp = 0;
   int n_err = 0;

   clk_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .continuous(continuous),
      .busy(busy), .valid(valid), .freq_cnt(freq_cnt), .overflow(overflow),
      .period_cnt(period_cnt)
   );

   clk_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .continuous(continuous),
      .busy(busy4), .valid(valid4), .freq_cnt(freq_cnt4), .overflow(overflow4),
      .period_cnt(period_cnt4)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit samp [SAMP_N];
   int cyc = 0;
   int rst_last = 0;

   always @(posedge clk) begin
      if (cyc < SAMP_N) samp[cyc] <= rst_n ? sig_in : 1'b0;
      cyc <= cyc + 1;
   end

   always @(negedge rst_n) rst_last <= cyc;

   function automatic bit samp_at(int k);
      if (k < 0 || k < rst_last || k >= SAMP_N) return 1'b0;
      return samp[k];
   endfunction

   // A rise in the sample history at index k is seen by the counter at clock k+2.
   function automatic int rises(int p, int d);
      int c = 0;
      for (int m = p + 1; m <= d; m++) if (samp_at(m - 2) && !samp_at(m - 3)) c++;
      return c;
   endfunction

   function automatic int span(int p, int d);
      int c = 0, f = -1, l = -1;
      for (int m = p + 1; m <= d; m++)
         if (samp_at(m - 2) && !samp_at(m - 3)) begin
            c++;
            if (f < 0) f = m;
            l = m;
         end
      return (PER_EN && c >= 2) ? (l - f) : 0;
   endfunction

   bit          m_active = 0, m_done = 0;
   int          m_p = 0, m_d = 0;
   longint      e_f32 = 0, e_f4 = 0, e_per = 0;
   bit          e_o4 = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 0; m_done <= 0;
         e_f32 <= 0; e_f4 <= 0; e_o4 <= 0; e_per <= 0;
      end else if (m_done) begin
         m_done <= 0;
         if (continuous) begin m_p <= cyc; m_d <= cyc + G; end
         else m_active <= 0;
      end else if (!m_active) begin
         if (start) begin m_active <= 1; m_p <= cyc; m_d <= cyc + G; end
      end else if (cyc == m_d) begin
         e_f32  <= rises(m_p, cyc);
         e_f4   <= (rises(m_p, cyc) > 15) ? 15 : rises(m_p, cyc);
         e_o4   <= (rises(m_p, cyc) > 15);
         e_per  <= span(m_p, cyc);
         m_done <= 1;
      end
   end

   always @(negedge clk) begin
      #1;
      check("m_busy",    busy,        m_active);
      check("m_valid",   valid,       m_done);
      check("m_freq",    freq_cnt,    e_f32);
      check("m_ovf",     overflow,    0);
      check("m_period",  period_cnt,  e_per);
      check("m_busy4",   busy4,       m_active);
      check("m_valid4",  valid4,      m_done);
      check("m_freq4",   freq_cnt4,   e_f4);
      check("m_ovf4",    overflow4,   e_o4);
      check("m_period4", period_cnt4, e_per);
   end

   // ---------------- table vectors ----------------
   typedef struct {
      int per; int high; int first; bit lvl;
      int f32; int f4; bit o4; int pcnt;
   } vec_t;
   vec_t vecs [9];

   function automatic bit pat(vec_t v, int j);
      if (v.per == 0) return v.lvl;
      if (j < v.first) return 1'b0;
      return ((j - v.first) % v.per) < v.high;
   endfunction

   task automatic hold(input int n, input bit lvl);
      repeat (n) begin
         @(negedge clk);
         start = 0;
         sig_in = lvl;
      end
   endtask

   task automatic apply_vec(input int id);
      vec_t v = vecs[id];
      int vat = -1;
      hold(5, (v.per == 0) ? v.lvl : 1'b0);
      for (int j = 0; j <= G + 5; j++) begin
         @(negedge clk);
         if (valid && vat < 0) begin
            vat = j;
            check($sformatf("v%0d freq", id),    freq_cnt,    v.f32);
            check($sformatf("v%0d ovf", id),     overflow,    0);
            check($sformatf("v%0d freq4", id),   freq_cnt4,   v.f4);
            check($sformatf("v%0d ovf4", id),    overflow4,   v.o4);
            check($sformatf("v%0d period", id),  period_cnt,  PER_EN ? v.pcnt : 0);
            check($sformatf("v%0d period4", id), period_cnt4, PER_EN ? v.pcnt : 0);
         end
         start  = (j == 0);
         sig_in = pat(v, j);
      end
      start = 0;
      check($sformatf("v%0d valid_at", id), vat, G + 1);
   endtask

   initial begin
      int nv, vat;
      int vt [8];
      int run;

      vecs[0] = '{10,   5,   3,  1'b0, 10, 10, 1'b0, 90};
      vecs[1] = '{0,    0,   0,  1'b1, 0,  0,  1'b0, 0};
      vecs[2] = '{4,    2,   1,  1'b0, 25, 15, 1'b1, 96};
      vecs[3] = '{0,    0,   0,  1'b0, 0,  0,  1'b0, 0};
      vecs[4] = '{20,   10,  2,  1'b0, 5,  5,  1'b0, 80};
      vecs[5] = '{1000, 500, 0,  1'b0, 1,  1,  1'b0, 0};
      vecs[6] = '{1000, 500, 98, 1'b0, 1,  1,  1'b0, 0};
      vecs[7] = '{1000, 500, 99, 1'b0, 0,  0,  1'b0, 0};
      vecs[8] = '{6,    3,   0,  1'b0, 17, 15, 1'b1, 96};

      // reset with sig_in toggling, then idle with no start
      repeat (3) @(negedge clk) sig_in = ~sig_in;
      @(negedge clk) rst_n = 1;
      repeat (10) @(negedge clk) sig_in = ~sig_in;
      #1;
      check("rst busy", busy, 0);
      check("rst valid", valid, 0);
      check("rst freq", freq_cnt, 0);
      check("rst ovf", overflow, 0);
      check("rst period", period_cnt, 0);

      for (int i = 0; i < 9; i++) apply_vec(i);

      // continuous windows, then drop continuous mid-window
      hold(5, 1'b0);
      continuous = 1;
      nv = 0;
      for (int j = 0; j <= 500; j++) begin
         @(negedge clk);
         if (valid) begin
            if (nv < 8) vt[nv] = j;
            nv++;
            check("cont freq", freq_cnt, 5);
            check("cont freq4", freq_cnt4, 5);
         end
         start  = (j == 0);
         sig_in = (j % 20) < 10;
         if (j == 250) continuous = 0;
      end
      check("cont nvalid", nv, 3);
      check("cont first", vt[0], G + 1);
      check("cont gap1", vt[1] - vt[0], G + 1);
      check("cont gap2", vt[2] - vt[1], G + 1);
      check("cont busy_end", busy, 0);

      // second start mid-window is ignored
      hold(5, 1'b0);
      nv = 0; vat = -1;
      for (int j = 0; j <= 210; j++) begin
         @(negedge clk);
         if (valid) begin
            nv++;
            vat = j;
            check("ign freq", freq_cnt, 10);
         end
         start  = (j == 0 || j == 50);
         sig_in = pat(vecs[0], j);
      end
      start = 0;
      check("ign nvalid", nv, 1);
      check("ign valid_at", vat, G + 1);

      // reset mid-window aborts, then a fresh measurement works
      hold(5, 1'b0);
      for (int j = 0; j < 60; j++) begin
         @(negedge clk);
         start  = (j == 0);
         sig_in = pat(vecs[0], j);
      end
      @(negedge clk);
      start = 0;
      rst_n = 0;
      #1;
      check("abort busy", busy, 0);
      check("abort valid", valid, 0);
      check("abort freq", freq_cnt, 0);
      check("abort busy4", busy4, 0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      apply_vec(0);

      // randomized traffic against the model
      run = 2;
      for (int j = 0; j < 3000; j++) begin
         @(negedge clk);
         if (run <= 1) begin
            sig_in = ~sig_in;
            run = (j < 1500) ? $urandom_range(2, 3) : $urandom_range(2, 12);
         end else run--;
         start = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 149) == 0) continuous = ~continuous;
         if (!rst_n) rst_n = 1;
         else if ($urandom_range(0, 1499) == 0) rst_n = 0;
      end
      @(negedge clk);
      rst_n = 1; start = 0; continuous = 0;
      repeat (250) @(negedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/clk_meter.md
Name: clk_meter

Overview:
- Frequency meter: counts rising edges of an asynchronous input over a fixed gate window of system clock cycles.
- Reports the count to the CPU or debug logic. It complements the board clock divider by measuring the divided clocks (CPU clock, clkdiv taps) or external signals.
- Sits on the system clock domain beside the clock divider; results are readable by the CPU or a seven-segment display driver.

Parameters:
- GATE_CYCLES, 100000000, gate window length in clk cycles (1 s at 100 MHz); must be >= 2.
- CNT_W, 32, width of the edge counter and freq_cnt.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sig_in  input  1  signal to measure; asynchronous to clk
- start  input  1  one-cycle request to begin a measurement
- continuous  input  1  1 = re-arm automatically after each window
- busy  output  1  high while a window is open or being reported
- valid  output  1  one-cycle pulse: new freq_cnt/overflow available
- freq_cnt  output  CNT_W  edges counted in the last completed window
- overflow  output  1  edge count saturated in the last completed window
- period_cnt  output  32  clk cycles from first to last counted edge (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, valid=0, freq_cnt=0, overflow=0, period_cnt=0, all internal counters and synchronizer flops = 0.
- sig_in passes through a 2-flop synchronizer plus a third history flop. An edge is s2 & ~s3, so edge detection has 2-3 cycles of latency; the window is effectively shifted by that amount.
- sig_in high and low times must each exceed one clk period; faster signals undercount (no requirement).
- FSM states:
  - IDLE: start=1 -> GATE; gate_cnt=0, edge_cnt=0, ovf=0.
  - GATE: gate_cnt += 1 each cycle. On an edge, edge_cnt += 1, saturating at 2^CNT_W-1; an edge arriving while saturated sets ovf. When gate_cnt == GATE_CYCLES-1, latch freq_cnt = edge_cnt including any edge in that same cycle (still saturating), latch overflow = ovf, then -> DONE.
  - DONE: valid=1 for this single cycle.
    - continuous=1 -> GATE with counters cleared.
    - Otherwise -> IDLE.
    - Edges detected in DONE are not counted.
- Window = exactly GATE_CYCLES cycles in GATE. A start seen in IDLE at cycle t yields valid at cycle t+1+GATE_CYCLES.
- busy = 1 in GATE and DONE, 0 in IDLE.
- start is ignored in GATE and DONE (no queuing).
- continuous is sampled only in DONE; dropping it mid-window ends after the current window.
- freq_cnt and overflow hold their values until the next DONE; they are unchanged by start.
- Reset mid-window aborts with no valid pulse; all outputs return to reset values.

Optional Feature:
- Macro CLK_METER_PERIOD_EN.
- Defined:
  - A 32-bit counter starts at 0 on the first edge in the window and increments every cycle thereafter (saturating).
  - At each edge it snapshots to last_edge_time.
  - In DONE, period_cnt = last_edge_time, or 0 if fewer than 2 edges were counted.
  - Software derives high-resolution frequency as (freq_cnt-1)*Fclk/period_cnt.
- Not defined: period_cnt is constant 0; no counter logic is synthesized.

Test Plan:
- Reset: rst_n low for 3 cycles with sig_in toggling -> busy=0, valid=0, freq_cnt=0, overflow=0, period_cnt=0, and they stay so with no start.
- GATE_CYCLES=100: sig_in period 10 clk (5 high/5 low), first rise 3 cycles after start -> valid exactly 101 cycles after start, freq_cnt=10, overflow=0; with the macro, period_cnt=90.
- sig_in held 1 throughout, start -> valid after 101 cycles, freq_cnt=0; period_cnt=0.
- continuous=1, sig_in period 20, GATE_CYCLES=100 -> valid every 101 cycles with freq_cnt=5 each. Clear continuous mid-window -> exactly one more valid, then busy=0.
- CNT_W=4, sig_in period 4, GATE_CYCLES=100 -> freq_cnt=15, overflow=1. Next window with sig_in static -> freq_cnt=0, overflow=0.
- start pulsed again at cycle 50 of a window -> ignored, single valid at 101. rst_n asserted at cycle 60 -> no valid, busy=0 immediately; new start afterwards -> normal result.
